regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file; next generation of the core's integer regfile.
//  - N registered read ports, one write port, optional hardwired-zero register 0,

---
 rtl/regfile_mp.sv | 115 +++++++++++
 tb/tb_regfile_mp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port integer register file with post-reset clear sweep.
// Registered reads, optional hardwired x0 and write-to-read bypass.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*XLEN-1:0]   rd_data,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  output logic                  ready
);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  localparam logic [AW:0]   NREGS_W = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   clr_ptr;
  logic [AW-1:0]   clr_ptr_nxt;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_ok;
  logic [AW-1:0]   rd_a   [NRD];
  logic [XLEN-1:0] rd_val [NRD];

  // Addresses past NREGS and (optionally) x0 never hold state.
  function automatic logic live(input logic [AW-1:0] a);
    logic zero;
    zero = (ZERO_REG != 0) && (a == '0);
    return ({1'b0, a} < NREGS_W) && !zero;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    unique case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == LAST) begin
          state_nxt   = READY;
          clr_ptr_nxt = '0;
        end
      end
      READY: begin
        state_nxt = READY;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign ready = (state == READY);
  assign wr_ok = ready && wr_en && live(wr_addr);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        regs[clr_ptr] <= '0;
      end else if (wr_ok) begin
        regs[wr_addr] <= wr_data;
      end
    end
  end

  // Dead addresses win over bypass; bypass wins over the array.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_a[i]   = rd_addr[i*AW +: AW];
      rd_val[i] = regs[rd_a[i]];
      if ((BYPASS != 0) && wr_ok && (wr_addr == rd_a[i])) begin
        rd_val[i] = wr_data;
      end
      if (!live(rd_a[i])) begin
        rd_val[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (ready) begin
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          rd_data[i*XLEN +: XLEN] <= rd_val[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default, no-bypass and 24-register instances
// share one stimulus stream; expectations are queued and popped per edge.
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [63:0] rd_d;
  logic [63:0] rd_nb;
  logic [63:0] rd_24;
  logic        ready_d;
  logic        ready_nb;
  logic        ready_24;

  regfile_mp dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_d), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ready(ready_d)
  );

  regfile_mp #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_nb), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ready(ready_nb)
  );

  regfile_mp #(.NREGS(24)) dut_24 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_24), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ready(ready_24)
  );

  typedef struct {
    logic            we;
    logic [4:0]      wa;
    logic [31:0]     wd;
    logic [1:0]      re;
    logic [4:0]      a0;
    logic [4:0]      a1;
    logic [5:0][31:0] e;
  } vec_t;

  typedef struct {
    int          sel;
    logic [31:0] val;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_cmp;
  int   n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic we, input logic [4:0] wa, input logic [31:0] wd,
    input logic [1:0] re, input logic [4:0] a0, input logic [4:0] a1,
    input logic [31:0] e0, input logic [31:0] e1,
    input logic [31:0] n0, input logic [31:0] n1,
    input logic [31:0] z0, input logic [31:0] z1);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.re = re; v.a0 = a0; v.a1 = a1;
    v.e  = {z1, z0, n1, n0, e1, e0};
    return v;
  endfunction

  function automatic logic [31:0] outv(input int sel);
    case (sel)
      0:       return rd_d[31:0];
      1:       return rd_d[63:32];
      2:       return rd_nb[31:0];
      3:       return rd_nb[63:32];
      4:       return rd_24[31:0];
      default: return rd_24[63:32];
    endcase
  endfunction

  function automatic string oname(input int sel);
    case (sel)
      0:       return "rd0";
      1:       return "rd1";
      2:       return "nb_rd0";
      3:       return "nb_rd1";
      4:       return "n24_rd0";
      default: return "n24_rd1";
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    wr_en   = v.we;
    wr_addr = v.wa;
    wr_data = v.wd;
    rd_en   = v.re;
    rd_addr = {v.a1, v.a0};
    for (int s = 0; s < 6; s++) begin
      sbq.push_back('{sel: s, val: v.e[s], idx: idx});
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      check($sformatf("vec%0d_%s", x.idx, oname(x.sel)),
            outv(x.sel), x.val);
    end
    wr_en = 1'b0;
    rd_en = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", {31'd0, ready_d}, 32'd0);
    check("rst_ready_24", {31'd0, ready_24}, 32'd0);
    check("rst_rd0", rd_d[31:0], 32'd0);
    check("rst_rd1", rd_d[63:32], 32'd0);
  endtask

  // Counts edges until ready; disturbs with writes/reads early on.
  task automatic sweep(input int noise, output int r32, output int r24);
    r32 = -1;
    r24 = -1;
    for (int i = 1; i <= 64; i++) begin
      wr_en   = (i <= noise);
      wr_addr = 5'd3;
      wr_data = 32'hAA;
      rd_en   = (i <= noise) ? 2'b11 : 2'b00;
      rd_addr = {5'd3, 5'd3};
      @(posedge clk);
      #1;
      if (r24 < 0 && ready_24) r24 = i;
      if (ready_d) begin
        r32 = i;
        break;
      end
    end
    wr_en = 1'b0;
    rd_en = 2'b00;
  endtask

  initial begin
    int r32;
    int r24;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    rd_en   = 2'b00;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (2) @(posedge clk);
    #1;

    do_reset();
    sweep(5, r32, r24);
    check("sweep_len", r32, 32);
    check("sweep_len_24", r24, 24);
    check("ready_nb", {31'd0, ready_nb}, 32'd1);
    check("clear_rd0", rd_d[31:0], 32'd0);
    check("clear_rd1", rd_d[63:32], 32'd0);

    for (int a = 0; a < 32; a += 2) begin
      vecs.push_back(mk(0, 0, 0, 2'b11, 5'(a), 5'(a + 1),
                        0, 0, 0, 0, 0, 0));
    end
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 2'b00, 0, 0,
                      0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'b11, 5, 5,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF));
    vecs.push_back(mk(1, 7, 32'h12345678, 2'b11, 7, 5,
                      32'h12345678, 32'hDEADBEEF, 0,
                      32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 2'b11, 7, 7,
                      32'h12345678, 32'h12345678, 32'h12345678,
                      32'h12345678, 32'h12345678, 32'h12345678));
    vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 2'b11, 0, 0,
                      0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'b11, 7, 0,
                      32'h12345678, 0, 32'h12345678, 0,
                      32'h12345678, 0));
    vecs.push_back(mk(0, 0, 0, 2'b10, 5, 5,
                      32'h12345678, 32'hDEADBEEF, 32'h12345678,
                      32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF));
    vecs.push_back(mk(1, 30, 32'hCAFEF00D, 2'b01, 30, 7,
                      32'hCAFEF00D, 32'hDEADBEEF, 0,
                      32'hDEADBEEF, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 2'b11, 30, 31,
                      32'hCAFEF00D, 0, 32'hCAFEF00D, 0, 0, 0));
    vecs.push_back(mk(1, 23, 32'h11112222, 2'b11, 23, 24,
                      32'h11112222, 0, 0, 0, 32'h11112222, 0));
    vecs.push_back(mk(0, 0, 0, 2'b11, 23, 5,
                      32'h11112222, 32'hDEADBEEF, 32'h11112222,
                      32'hDEADBEEF, 32'h11112222, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0, 2'b11, 5, 7,
                      32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF,
                      32'h12345678, 32'hDEADBEEF, 32'h12345678));
    foreach (vecs[k]) apply(vecs[k], k);

    do_reset();
    repeat (10) @(posedge clk);
    #1;
    check("midsweep_not_ready", {31'd0, ready_d}, 32'd0);
    do_reset();
    sweep(0, r32, r24);
    check("resweep_len", r32, 32);
    check("resweep_len_24", r24, 24);
    apply(mk(1, 9, 32'h55AA55AA, 2'b11, 5, 9,
             0, 32'h55AA55AA, 0, 0, 0, 32'h55AA55AA), 100);
    apply(mk(0, 0, 0, 2'b11, 7, 9,
             0, 32'h55AA55AA, 0, 32'h55AA55AA, 0, 32'h55AA55AA), 101);
    apply(mk(0, 0, 0, 2'b11, 23, 30,
             0, 0, 0, 0, 0, 0), 102);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
